// File: rtl/memory_writeback_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_writeback_pipe_if                                                   |
// | Write-back pipe bundle: write requests, load returns, bypass lookups.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface memory_writeback_pipe_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 5,
  parameter int BYPASS_PORTS = 2
);
  logic                               stall;
  logic                               flush;
  logic [2:0]                         wbLoadMode;
  logic [DATA_WIDTH-1:0]              wbWriteDataIn;
  logic [INDEX_WIDTH-1:0]             wbWriteIndexIn;
  logic                               wbWriteEnableIn;
  logic                               loadDataValid;
  logic [31:0]                        loadData;
  logic [BYPASS_PORTS*INDEX_WIDTH-1:0] lookupIndex;
  logic [BYPASS_PORTS-1:0]            lookupHit;
  logic [BYPASS_PORTS-1:0]            lookupPending;
  logic [BYPASS_PORTS*DATA_WIDTH-1:0] lookupData;
  logic [DATA_WIDTH-1:0]              wbWriteData;
  logic [INDEX_WIDTH-1:0]             wbWriteIndex;
  logic                               wbWriteEnable;
  logic                               wbStageLoadPending;
  logic                               loadStall;

  modport master (
    output stall, flush, wbLoadMode, wbWriteDataIn, wbWriteIndexIn, wbWriteEnableIn,
           loadDataValid, loadData, lookupIndex,
    input  lookupHit, lookupPending, lookupData, wbWriteData, wbWriteIndex,
           wbWriteEnable, wbStageLoadPending, loadStall
  );

  modport slave (
    input  stall, flush, wbLoadMode, wbWriteDataIn, wbWriteIndexIn, wbWriteEnableIn,
           loadDataValid, loadData, lookupIndex,
    output lookupHit, lookupPending, lookupData, wbWriteData, wbWriteIndex,
           wbWriteEnable, wbStageLoadPending, loadStall
  );
endinterface
`default_nettype wire

// File: rtl/memory_writeback_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_writeback_pipe                                                      |
// | Multi-stage write-back pipe with in-order load merge, bypass and stall.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module memory_writeback_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 5,
  parameter int NR_STAGES    = 2,
  parameter int BYPASS_PORTS = 2
) (
  input wire                      cpuClock,
  input wire                      cpuResetN,
  memory_writeback_pipe_if.slave  bus
);

  localparam int OUT = NR_STAGES - 1;

  logic [NR_STAGES-1:0]   en_q, en_d;
  logic [NR_STAGES-1:0]   pend_q, pend_d;
  logic [2:0]             mode_q [NR_STAGES];
  logic [2:0]             mode_d [NR_STAGES];
  logic [INDEX_WIDTH-1:0] idx_q  [NR_STAGES];
  logic [INDEX_WIDTH-1:0] idx_d  [NR_STAGES];
  logic [DATA_WIDTH-1:0]  data_q [NR_STAGES];
  logic [DATA_WIDTH-1:0]  data_d [NR_STAGES];

  logic                   w_load_stall;
  logic                   w_advance;
  logic                   w_merge_found;
  logic [2:0]             w_merge_sel;
  logic [2:0]             w_merge_pos;
  logic [2:0]             w_merge_mode;
  logic [DATA_WIDTH-1:0]  w_merge_data;

  logic [BYPASS_PORTS-1:0]            w_hit;
  logic [BYPASS_PORTS-1:0]            w_lpend;
  logic [BYPASS_PORTS*DATA_WIDTH-1:0] w_ldata;

  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [31:0] raw,
                                                        input logic [2:0]  mode);
    logic [31:0] w;
    case (mode[1:0])
      2'b01:   w = {{24{mode[2] & raw[7]}}, raw[7:0]};
      2'b10:   w = {{16{mode[2] & raw[15]}}, raw[15:0]};
      default: w = raw;
    endcase
    return DATA_WIDTH'(w);
  endfunction

  assign w_load_stall = pend_q[OUT] & ~bus.loadDataValid;
  assign w_advance    = ~bus.stall & ~w_load_stall;

  // Highest pending index is the oldest outstanding load.
  always_comb begin
    w_merge_found = 1'b0;
    w_merge_sel   = '0;
    w_merge_mode  = '0;
    for (int k = 0; k < NR_STAGES; k++) begin
      if (pend_q[k]) begin
        w_merge_found = 1'b1;
        w_merge_sel   = 3'(k);
        w_merge_mode  = mode_q[k];
      end
    end
  end

  assign w_merge_data = extend_load(bus.loadData, w_merge_mode);
  // A merge into the output entry on an advancing edge lands past the end and retires.
  assign w_merge_pos  = w_advance ? (w_merge_sel + 3'd1) : w_merge_sel;

  always_comb begin
    en_d   = en_q;
    pend_d = pend_q;
    mode_d = mode_q;
    idx_d  = idx_q;
    data_d = data_q;
    if (w_advance) begin
      for (int k = NR_STAGES - 1; k > 0; k--) begin
        en_d[k]   = en_q[k-1];
        pend_d[k] = pend_q[k-1];
        mode_d[k] = mode_q[k-1];
        idx_d[k]  = idx_q[k-1];
        data_d[k] = data_q[k-1];
      end
      en_d[0]   = bus.wbWriteEnableIn;
      pend_d[0] = (bus.wbLoadMode != 3'd0);
      mode_d[0] = bus.wbLoadMode;
      idx_d[0]  = bus.wbWriteIndexIn;
      data_d[0] = bus.wbWriteDataIn;
    end
    if (bus.loadDataValid && w_merge_found) begin
      for (int k = 0; k < NR_STAGES; k++) begin
        if (3'(k) == w_merge_pos) begin
          data_d[k] = w_merge_data;
          pend_d[k] = 1'b0;
        end
      end
    end
    // Flushed entries keep pend/mode so late returns are still absorbed.
    if (bus.flush) begin
      en_d = '0;
    end
  end

  always_ff @(posedge cpuClock or negedge cpuResetN) begin
    if (!cpuResetN) begin
      en_q   <= '0;
      pend_q <= '0;
      for (int k = 0; k < NR_STAGES; k++) begin
        mode_q[k] <= '0;
        idx_q[k]  <= '0;
        data_q[k] <= '0;
      end
    end else begin
      en_q   <= en_d;
      pend_q <= pend_d;
      mode_q <= mode_d;
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    logic [INDEX_WIDTH-1:0] li;
    li      = '0;
    w_hit   = '0;
    w_lpend = '0;
    w_ldata = '0;
    for (int p = 0; p < BYPASS_PORTS; p++) begin
      li = bus.lookupIndex[p*INDEX_WIDTH +: INDEX_WIDTH];
      for (int k = OUT; k >= 0; k--) begin
        if (en_q[k] && (idx_q[k] == li) && (li != '0)) begin
          w_hit[p]                          = 1'b1;
          w_lpend[p]                        = pend_q[k];
          w_ldata[p*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
        end
      end
    end
  end

  assign bus.lookupHit          = w_hit;
  assign bus.lookupPending      = w_lpend;
  assign bus.lookupData         = w_ldata;
  assign bus.wbWriteData        = data_q[OUT];
  assign bus.wbWriteIndex       = idx_q[OUT];
  assign bus.wbWriteEnable      = en_q[OUT] & ~pend_q[OUT];
  assign bus.wbStageLoadPending = pend_q[OUT];
  assign bus.loadStall          = w_load_stall;

endmodule
`default_nettype wire
